aes_stream: RTL and testbench

Byte-serial front end for the iterative AES encrypt/decrypt core. It collects a 128-bit key and a 128-bit data block from an 8-bit valid/ready stream and launches one core operation with a single-cycle valid strobe. It then captures the core's 128-bit result and streams it back out as 16 bytes. The block sits between a host bus or UART bridge and the AES core and acts as the initiator on the core's parallel interface.

---
 rtl/aes_stream.sv | 211 +++++++++++++++++++++
 tb/tb_aes_stream.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_stream.sv
// ---------------------------------------------------------------------------
// aes_stream
// Byte-serial front end for an iterative AES encrypt/decrypt core.
// Collects a 128-bit key and/or a 128-bit data block from an 8-bit
// valid/ready stream, launches one core operation with a one-cycle strobe,
// captures the 128-bit result and streams it back out as 16 bytes.
// Byte order: first byte of a block <-> bits [0:7], 16th byte <-> [120:127].
//
// Optional feature macro: AES_STREAM_TIMEOUT_EN
//   defined   : WAIT gives up after TIMEOUT cycles, pulses err_o, returns
//               to IDLE with the stored key retained.
//   undefined : WAIT waits indefinitely for the core; TIMEOUT is unused.
//
// Ports:
//   clk_i, reset_i          clock (rising edge), async active-low reset
//   din_i/din_valid_i/din_ready_o      input byte stream
//   mode_i, key_new_i       frame attributes, sampled with the first byte
//   dout_o/dout_valid_o/dout_ready_i   output byte stream
//   err_o                   one-cycle error pulse
//   aes_mode_o/aes_key_o/aes_data_o/aes_valid_o   launch side of the core
//   aes_data_i/aes_valid_i  result side of the core
// ---------------------------------------------------------------------------
module aes_stream #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic [7:0]   din_i,
    input  logic         din_valid_i,
    output logic         din_ready_o,
    input  logic         mode_i,
    input  logic         key_new_i,
    output logic [7:0]   dout_o,
    output logic         dout_valid_o,
    input  logic         dout_ready_i,
    output logic         err_o,
    output logic         aes_mode_o,
    output logic [0:127] aes_key_o,
    output logic [0:127] aes_data_o,
    output logic         aes_valid_o,
    input  logic [0:127] aes_data_i,
    input  logic         aes_valid_i
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_KEY   = 3'd1,
        ST_DATA  = 3'd2,
        ST_START = 3'd3,
        ST_WAIT  = 3'd4,
        ST_SEND  = 3'd5
    } state_t;

    state_t       state_r;
    logic [3:0]   cnt_r;
    logic         key_valid_r;
    logic         mode_r;
    logic [0:127] key_r;
    logic [0:127] data_r;
    logic [0:127] shift_r;
    logic         din_ready_r;
    logic         dout_valid_r;
    logic         err_r;
    logic         aes_valid_r;
    logic         aes_mode_r;
    logic [0:127] aes_key_r;
    logic [0:127] aes_data_r;

    logic         din_accept_s;
    logic         dout_accept_s;
    logic         last_byte_s;

`ifdef AES_STREAM_TIMEOUT_EN
    localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    logic [TMO_W-1:0] tmo_cnt_r;
`else
    // TIMEOUT only has meaning when the timeout feature is compiled in.
    if (TIMEOUT == 0) begin : g_timeout_unused
    end
`endif

    // Handshake qualifiers; ready/valid are registered so these never reach outputs.
    assign din_accept_s  = din_valid_i & din_ready_r;
    assign dout_accept_s = dout_valid_r & dout_ready_i;
    assign last_byte_s   = (cnt_r == 4'd15);

    // Frame sequencer: state, byte counter, key/data capture and all registered outputs.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 4'd0;
            key_valid_r  <= 1'b0;
            mode_r       <= 1'b0;
            key_r        <= 128'd0;
            data_r       <= 128'd0;
            shift_r      <= 128'd0;
            din_ready_r  <= 1'b0;
            dout_valid_r <= 1'b0;
            err_r        <= 1'b0;
            aes_valid_r  <= 1'b0;
            aes_mode_r   <= 1'b0;
            aes_key_r    <= 128'd0;
            aes_data_r   <= 128'd0;
`ifdef AES_STREAM_TIMEOUT_EN
            tmo_cnt_r    <= '0;
`endif
        end else begin
            err_r       <= 1'b0;
            aes_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    din_ready_r <= 1'b1;
                    if (din_accept_s) begin
                        mode_r <= mode_i;
                        if (key_new_i) begin
                            // A partially overwritten key is unusable until all 16 bytes land.
                            key_r       <= {key_r[8:127], din_i};
                            key_valid_r <= 1'b0;
                            cnt_r       <= 4'd1;
                            state_r     <= ST_KEY;
                        end else if (key_valid_r) begin
                            data_r  <= {data_r[8:127], din_i};
                            cnt_r   <= 4'd1;
                            state_r <= ST_DATA;
                        end else begin
                            err_r <= 1'b1;
                        end
                    end
                end
                ST_KEY: begin
                    if (din_accept_s) begin
                        key_r <= {key_r[8:127], din_i};
                        cnt_r <= cnt_r + 4'd1;
                        if (last_byte_s) begin
                            key_valid_r <= 1'b1;
                            state_r     <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (din_accept_s) begin
                        data_r <= {data_r[8:127], din_i};
                        cnt_r  <= cnt_r + 4'd1;
                        if (last_byte_s) begin
                            // Launch registers load here so they are stable in START.
                            din_ready_r <= 1'b0;
                            aes_valid_r <= 1'b1;
                            aes_mode_r  <= mode_r;
                            aes_key_r   <= key_r;
                            aes_data_r  <= {data_r[8:127], din_i};
                            state_r     <= ST_START;
                        end
                    end
                end
                ST_START: begin
`ifdef AES_STREAM_TIMEOUT_EN
                    tmo_cnt_r <= '0;
`endif
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (aes_valid_i) begin
                        shift_r      <= aes_data_i;
                        dout_valid_r <= 1'b1;
                        state_r      <= ST_SEND;
                    end else begin
`ifdef AES_STREAM_TIMEOUT_EN
                        if (tmo_cnt_r == TMO_LAST) begin
                            err_r       <= 1'b1;
                            din_ready_r <= 1'b1;
                            state_r     <= ST_IDLE;
                        end else begin
                            tmo_cnt_r <= tmo_cnt_r + 1'b1;
                        end
`else
                        state_r <= ST_WAIT;
`endif
                    end
                end
                ST_SEND: begin
                    if (dout_accept_s) begin
                        shift_r <= {shift_r[8:127], 8'h00};
                        cnt_r   <= cnt_r + 4'd1;
                        if (last_byte_s) begin
                            dout_valid_r <= 1'b0;
                            din_ready_r  <= 1'b1;
                            state_r      <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    cnt_r        <= 4'd0;
                    din_ready_r  <= 1'b1;
                    dout_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign din_ready_o  = din_ready_r;
    assign dout_o       = shift_r[0:7];
    assign dout_valid_o = dout_valid_r;
    assign err_o        = err_r;
    assign aes_mode_o   = aes_mode_r;
    assign aes_key_o    = aes_key_r;
    assign aes_data_o   = aes_data_r;
    assign aes_valid_o  = aes_valid_r;

endmodule

// File: tb/tb_aes_stream.sv
// ---------------------------------------------------------------------------
// tb_aes_stream
// Directed + randomized bench for aes_stream. A stub core answers each launch
// after a random latency: it returns the FIPS-197 C.1 vectors for the known
// key/block pairs and a simple reversible scramble for anything else. The
// expected output of every frame is derived from the key/data the bench sent.
// ---------------------------------------------------------------------------
module tb_aes_stream;

    localparam logic [0:127] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [0:127] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         reset_i;
    logic [7:0]   din_i;
    logic         din_valid_i;
    logic         din_ready_o;
    logic         mode_i;
    logic         key_new_i;
    logic [7:0]   dout_o;
    logic         dout_valid_o;
    logic         dout_ready_i;
    logic         err_o;
    logic         aes_mode_o;
    logic [0:127] aes_key_o;
    logic [0:127] aes_data_o;
    logic         aes_valid_o;
    logic [0:127] aes_data_i;
    logic         aes_valid_i;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int av_cnt = 0, av_cyc = 0, err_cnt = 0, err_cyc = 0, dv_cnt = 0;
    int core_cyc = 0;
    logic core_en = 1'b1;

    logic         m_key_valid;
    logic [0:127] m_key;

    aes_stream #(.TIMEOUT(8)) dut (
        .clk_i(clk), .reset_i(reset_i),
        .din_i(din_i), .din_valid_i(din_valid_i), .din_ready_o(din_ready_o),
        .mode_i(mode_i), .key_new_i(key_new_i),
        .dout_o(dout_o), .dout_valid_o(dout_valid_o), .dout_ready_i(dout_ready_i),
        .err_o(err_o),
        .aes_mode_o(aes_mode_o), .aes_key_o(aes_key_o), .aes_data_o(aes_data_o),
        .aes_valid_o(aes_valid_o), .aes_data_i(aes_data_i), .aes_valid_i(aes_valid_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event monitors sampled on the falling edge.
    always @(negedge clk) begin
        if (aes_valid_o) begin av_cnt++; av_cyc = cyc; end
        if (err_o) begin err_cnt++; err_cyc = cyc; end
        if (dout_valid_o) dv_cnt++;
    end

    // Behaviour of the core as seen by the block: C.1 vectors or a scramble.
    function automatic logic [0:127] core_fn(input logic m, input logic [0:127] k, input logic [0:127] d);
        if (!m && k == C1_KEY && d == C1_PT) return C1_CT;
        if (m && k == C1_KEY && d == C1_CT) return C1_PT;
        return d ^ k ^ {16{8'h5a}} ^ {128{m}};
    endfunction

    // Stub core: answers each launch after 1..5 cycles.
    initial begin
        aes_data_i  = 128'd0;
        aes_valid_i = 1'b0;
        forever begin
            @(negedge clk);
            if (aes_valid_o && core_en) begin
                repeat ($urandom_range(1, 5)) @(negedge clk);
                aes_data_i  = core_fn(aes_mode_o, aes_key_o, aes_data_o);
                aes_valid_i = 1'b1;
                core_cyc    = cyc;
                @(negedge clk);
                aes_valid_i = 1'b0;
                aes_data_i  = {$urandom, $urandom, $urandom, $urandom};
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic md, input logic kn,
                             input int gap, output int acc_cyc);
        int w;
        w = 0;
        repeat (gap) begin din_valid_i = 1'b0; @(negedge clk); end
        din_i = b; mode_i = md; key_new_i = kn; din_valid_i = 1'b1;
        while (!din_ready_o && w < 100) begin @(negedge clk); w++; end
        if (w >= 100) chk("din_ready_wait", din_ready_o, 1);
        acc_cyc = cyc;
        @(negedge clk);
        din_valid_i = 1'b0;
    endtask

    task automatic send_frame(input logic md, input logic kn, input logic [0:127] key,
                              input logic [0:127] data, input int max_gap, output int last_cyc);
        int c;
        if (kn)
            for (int i = 0; i < 16; i++)
                send_byte(key[8*i +: 8], md, kn, $urandom_range(0, max_gap), c);
        for (int i = 0; i < 16; i++)
            send_byte(data[8*i +: 8], md, kn, $urandom_range(0, max_gap), c);
        last_cyc = c;
    endtask

    task automatic recv_frame(input logic [0:127] exp, input bit bp, input string tag);
        int got, w;
        logic [7:0] held;
        bit hold_pending, first;
        got = 0; w = 0; hold_pending = 0; first = 1; held = 8'h00;
        while (got < 16 && w < 400) begin
            dout_ready_i = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (dout_valid_o) begin
                if (first) begin
                    chk({tag, "_first_byte_latency"}, cyc, core_cyc + 1);
                    first = 0;
                end
                if (hold_pending) chk({tag, "_stable"}, dout_o, held);
                if (dout_ready_i) begin
                    chk($sformatf("%s_byte%0d", tag, got), dout_o, exp[8*got +: 8]);
                    got++;
                    hold_pending = 0;
                end else begin
                    held = dout_o;
                    hold_pending = 1;
                end
            end
            @(negedge clk);
            w++;
        end
        dout_ready_i = 1'b0;
        chk({tag, "_count"}, got, 16);
        chk({tag, "_dout_valid_after"}, dout_valid_o, 0);
        chk({tag, "_din_ready_after"}, din_ready_o, 1);
    endtask

    initial begin
        int last, e0, a0, d0, w;
        logic md, kn;
        logic [0:127] k, d;

        reset_i = 1'b0; din_i = 8'h00; din_valid_i = 1'b0; mode_i = 1'b0;
        key_new_i = 1'b0; dout_ready_i = 1'b0;
        m_key_valid = 1'b0; m_key = 128'd0;
        repeat (3) @(negedge clk);
        chk("rst_din_ready", din_ready_o, 0);
        chk("rst_dout", {dout_o, dout_valid_o, err_o, aes_mode_o, aes_valid_o}, 0);
        chk("rst_aes_key", aes_key_o, 0);
        chk("rst_aes_data", aes_data_o, 0);
        reset_i = 1'b1;
        @(negedge clk);
        chk("post_rst_din_ready", din_ready_o, 1);

        // Data-only frame with no key held: every byte errors, nothing launches.
        e0 = err_cnt; a0 = av_cnt;
        send_frame(1'b0, 1'b0, 128'd0, C1_PT, 0, last);
        repeat (2) @(negedge clk);
        chk("nokey_err_count", err_cnt - e0, 16);
        chk("nokey_err_timing", err_cyc, last + 1);
        chk("nokey_no_launch", av_cnt - a0, 0);
        chk("nokey_idle", din_ready_o, 1);

        // FIPS-197 C.1 encrypt, back-to-back.
        a0 = av_cnt;
        send_frame(1'b0, 1'b1, C1_KEY, C1_PT, 0, last);
        m_key = C1_KEY; m_key_valid = 1'b1;
        recv_frame(C1_CT, 0, "c1_enc");
        chk("c1_launch_count", av_cnt - a0, 1);
        chk("c1_launch_timing", av_cyc, last + 1);
        chk("c1_aes_key", aes_key_o, C1_KEY);
        chk("c1_aes_data", aes_data_o, C1_PT);
        chk("c1_aes_mode", aes_mode_o, 0);

        // Key reuse: decrypt with the held key.
        a0 = av_cnt;
        send_frame(1'b1, 1'b0, 128'd0, C1_CT, 0, last);
        recv_frame(C1_PT, 0, "c1_dec");
        chk("dec_launch_count", av_cnt - a0, 1);
        chk("dec_aes_key", aes_key_o, C1_KEY);
        chk("dec_aes_mode", aes_mode_o, 1);

        // Random frames with input gaps and output backpressure.
        for (int i = 0; i < 5; i++) begin
            md = 1'($urandom_range(0, 1));
            kn = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            k  = {$urandom, $urandom, $urandom, $urandom};
            d  = {$urandom, $urandom, $urandom, $urandom};
            send_frame(md, kn, k, d, 3, last);
            if (kn) m_key = k;
            recv_frame(core_fn(md, m_key, d), 1, $sformatf("rnd%0d", i));
            chk($sformatf("rnd%0d_aes_key", i), aes_key_o, m_key);
            chk($sformatf("rnd%0d_aes_mode", i), aes_mode_o, md);
        end

`ifdef AES_STREAM_TIMEOUT_EN
        // Core never answers: timeout error 8 cycles after WAIT entry.
        core_en = 1'b0;
        e0 = err_cnt; d0 = dv_cnt;
        d = {$urandom, $urandom, $urandom, $urandom};
        send_frame(1'b0, 1'b0, 128'd0, d, 0, last);
        w = 0;
        while (err_cnt == e0 && w < 100) begin @(negedge clk); w++; end
        chk("tmo_err_count", err_cnt - e0, 1);
        chk("tmo_err_timing", err_cyc, av_cyc + 9);
        @(negedge clk);
        chk("tmo_din_ready", din_ready_o, 1);
        chk("tmo_no_output", dv_cnt - d0, 0);
        core_en = 1'b1;
        // Key survives a timeout.
        send_frame(1'b0, 1'b0, 128'd0, d, 0, last);
        recv_frame(core_fn(1'b0, m_key, d), 0, "tmo_keep");
`endif

        // Reset after 20 bytes of a key frame.
        k = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 16; i++) send_byte(k[8*i +: 8], 1'b0, 1'b1, 0, last);
        for (int i = 0; i < 4; i++) send_byte(8'(i), 1'b0, 1'b1, 0, last);
        reset_i = 1'b0;
        #1;
        chk("midrst_din_ready", din_ready_o, 0);
        chk("midrst_outs", {dout_o, dout_valid_o, err_o, aes_mode_o, aes_valid_o}, 0);
        chk("midrst_aes_key", aes_key_o, 0);
        chk("midrst_aes_data", aes_data_o, 0);
        @(negedge clk);
        reset_i = 1'b1;
        @(negedge clk);
        m_key_valid = 1'b0;
        e0 = err_cnt; a0 = av_cnt;
        send_frame(1'b0, 1'b0, 128'd0, C1_PT, 0, last);
        repeat (2) @(negedge clk);
        chk("midrst_nokey_err", err_cnt - e0, 16);
        chk("midrst_no_launch", av_cnt - a0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
